// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared class codes, ALU codes and constants for the execute stage
package ex_stage_pkg;

    // Instruction classes presented by decode
    typedef enum logic [2:0] {
        EX_CMP   = 3'd0,
        EX_OP    = 3'd1,
        EX_OPI   = 3'd2,
        EX_LUI   = 3'd3,
        EX_AUIPC = 3'd4,
        EX_JAL   = 3'd5,
        EX_JALR  = 3'd6,
        EX_MEM   = 3'd7
    } ex_class_e;

    // Operation types understood by the ALU
    typedef enum logic [1:0] {
        ALU_CMP    = 2'd0,
        ALU_ALUOP  = 2'd1,
        ALU_ALUOPI = 2'd2
    } alu_type_e;

    // Stage occupancy; the redirect flag rides on top of FULL
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ex_state_e;

    // Arithmetic/logic funct3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    // Branch funct3 codes (2 and 3 are not branches)
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // funct7[5] meanings
    localparam logic ADD_Diff = 1'b0;
    localparam logic SUB_Diff = 1'b1;
    localparam logic SRL_Diff = 1'b0;
    localparam logic SRA_Diff = 1'b1;

    localparam logic [31:0] TrueWord  = 32'h0000_0001;
    localparam logic [31:0] FalseWord = 32'h0000_0000;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Jump-register targets always land on an even address
    function automatic logic [31:0] clear_bit0(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - combinational ALU for compares, register and immediate operations
module ex_stage_alu
    import ex_stage_pkg::*;
(
    input  alu_type_e   alu_type_i,
    input  logic [2:0]  ins_details_i,
    input  logic        ins_diff_i,
    input  logic [31:0] r1_i,
    input  logic [31:0] r2_i,
    output logic [31:0] result_o
);

    logic        is_imm;
    logic        diff_clear;
    logic [4:0]  shamt;

    assign is_imm     = (alu_type_i == ALU_ALUOPI);
    // funct7[5] must be clear for ops that have no alternate form; immediates carry no funct7 there
    assign diff_clear = is_imm || (ins_diff_i == 1'b0);
    assign shamt      = r2_i[4:0];

    // Result selection; illegal combinations fall through to ZeroWord/FalseWord
    always_comb begin
        result_o = ZeroWord;
        case (alu_type_i)
            ALU_CMP: begin
                case (ins_details_i)
                    F3_BEQ:  result_o = (r1_i == r2_i) ? TrueWord : FalseWord;
                    F3_BNE:  result_o = (r1_i != r2_i) ? TrueWord : FalseWord;
                    F3_BLT:  result_o = ($signed(r1_i) <  $signed(r2_i)) ? TrueWord : FalseWord;
                    F3_BGE:  result_o = ($signed(r1_i) >= $signed(r2_i)) ? TrueWord : FalseWord;
                    F3_BLTU: result_o = (r1_i <  r2_i) ? TrueWord : FalseWord;
                    F3_BGEU: result_o = (r1_i >= r2_i) ? TrueWord : FalseWord;
                    default: result_o = FalseWord;
                endcase
            end
            ALU_ALUOP, ALU_ALUOPI: begin
                case (ins_details_i)
                    F3_ADD_SUB: begin
                        if (!is_imm && ins_diff_i == SUB_Diff) result_o = r1_i - r2_i;
                        else                                   result_o = r1_i + r2_i;
                    end
                    F3_SLL: begin
                        if (ins_diff_i == 1'b0) result_o = r1_i << shamt;
                    end
                    F3_SLT: begin
                        if (diff_clear) result_o = ($signed(r1_i) < $signed(r2_i)) ? TrueWord : FalseWord;
                    end
                    F3_SLTU: begin
                        if (diff_clear) result_o = (r1_i < r2_i) ? TrueWord : FalseWord;
                    end
                    F3_XOR: begin
                        if (diff_clear) result_o = r1_i ^ r2_i;
                    end
                    F3_SRL_SRA: begin
                        if (ins_diff_i == SRA_Diff) result_o = 32'($signed(r1_i) >>> shamt);
                        else                        result_o = r1_i >> shamt;
                    end
                    F3_OR: begin
                        if (diff_clear) result_o = r1_i | r2_i;
                    end
                    F3_AND: begin
                        if (diff_clear) result_o = r1_i & r2_i;
                    end
                    default: result_o = ZeroWord;
                endcase
            end
            default: result_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand select, branch resolve, registered result and redirect
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            flush_in,
    input  logic            id_valid_in,
    output logic            id_ready_out,
    input  logic [2:0]      id_class_in,
    input  logic [2:0]      id_funct3_in,
    input  logic            id_diff_in,
    input  logic [XLEN-1:0] id_pc_in,
    input  logic [XLEN-1:0] id_rs1_in,
    input  logic [XLEN-1:0] id_rs2_in,
    input  logic [XLEN-1:0] id_imm_in,
    input  logic [4:0]      id_rd_in,
    output logic            ex_valid_out,
    input  logic            ex_ready_in,
    output logic [XLEN-1:0] ex_result_out,
    output logic [XLEN-1:0] ex_store_out,
    output logic [4:0]      ex_rd_out,
    output logic [2:0]      ex_funct3_out,
    output logic            ex_is_mem_out,
    output logic            redirect_out,
    output logic [XLEN-1:0] redirect_pc_out
);

    ex_class_e       cls;
    alu_type_e       alu_type;
    logic [XLEN-1:0] alu_r2;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_imm_sum;
    logic [XLEN-1:0] rs1_imm_sum;
    logic [XLEN-1:0] link_addr;
    logic            accept;

    logic [XLEN-1:0] result_d;
    logic [4:0]      rd_d;
    logic            is_mem_d;
    logic            taken_d;
    logic [XLEN-1:0] target_d;

    ex_state_e       state_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] store_q;
    logic [4:0]      rd_q;
    logic [2:0]      funct3_q;
    logic            is_mem_q;

    assign cls = ex_class_e'(id_class_in);

    // Refuse input while reset is held, while the result is stalled, during a redirect, or on flush
    assign id_ready_out = rst_in & (!ex_valid_out | ex_ready_in) & !redirect_out & !flush_in;
    assign accept       = id_valid_in & id_ready_out;

    // Branch-target adder kept apart from the ALU so compares and target math run in parallel
    assign pc_imm_sum  = id_pc_in + id_imm_in;
    assign rs1_imm_sum = id_rs1_in + id_imm_in;
    assign link_addr   = id_pc_in + 32'd4;

    assign alu_type = (cls == EX_CMP) ? ALU_CMP : (cls == EX_OPI) ? ALU_ALUOPI : ALU_ALUOP;
    assign alu_r2   = (cls == EX_OPI) ? id_imm_in : id_rs2_in;

    ex_stage_alu u_alu (
        .alu_type_i    (alu_type),
        .ins_details_i (id_funct3_in),
        .ins_diff_i    (id_diff_in),
        .r1_i          (id_rs1_in),
        .r2_i          (alu_r2),
        .result_o      (alu_result)
    );

    // Per-class result, destination, and branch/jump resolution
    always_comb begin
        result_d = alu_result;
        rd_d     = id_rd_in;
        is_mem_d = 1'b0;
        taken_d  = 1'b0;
        target_d = pc_imm_sum;
        case (cls)
            EX_CMP: begin
                rd_d    = 5'd0;
                taken_d = (alu_result == TrueWord);
            end
            EX_OP, EX_OPI: result_d = alu_result;
            EX_LUI:        result_d = id_imm_in;
            EX_AUIPC:      result_d = pc_imm_sum;
            EX_JAL: begin
                result_d = link_addr;
                taken_d  = 1'b1;
            end
            EX_JALR: begin
                result_d = link_addr;
                taken_d  = 1'b1;
                target_d = clear_bit0(rs1_imm_sum);
            end
            EX_MEM: begin
                result_d = rs1_imm_sum;
                is_mem_d = 1'b1;
            end
            default: result_d = ZeroWord;
        endcase
    end

    // Occupancy FSM with the one-cycle redirect flag; flush beats everything but reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_EMPTY;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (flush_in) begin
            state_q    <= ST_EMPTY;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= accept & taken_d;
            if (accept && taken_d) redirect_pc_q <= target_d;
            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_FULL;
                ST_FULL:  if (!accept && ex_ready_in) state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    // Result payload loads only on accept, so a stalled result stays frozen
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            is_mem_q <= 1'b0;
        end else if (accept) begin
            result_q <= result_d;
            store_q  <= id_rs2_in;
            rd_q     <= rd_d;
            funct3_q <= id_funct3_in;
            is_mem_q <= is_mem_d;
        end
    end

    assign ex_valid_out    = (state_q == ST_FULL);
    assign ex_result_out   = result_q;
    assign ex_store_out    = store_q;
    assign ex_rd_out       = rd_q;
    assign ex_funct3_out   = funct3_q;
    assign ex_is_mem_out   = is_mem_q;
    assign redirect_out    = redirect_q;
    assign redirect_pc_out = redirect_pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed vector bench for ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_class;
    logic [2:0]  id_funct3;
    logic        id_diff;
    logic [31:0] id_pc, id_rs1, id_rs2, id_imm;
    logic [4:0]  id_rd;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result, ex_store;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_is_mem;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        diff;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_mem;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .flush_in        (flush),
        .id_valid_in     (id_valid),
        .id_ready_out    (id_ready),
        .id_class_in     (id_class),
        .id_funct3_in    (id_funct3),
        .id_diff_in      (id_diff),
        .id_pc_in        (id_pc),
        .id_rs1_in       (id_rs1),
        .id_rs2_in       (id_rs2),
        .id_imm_in       (id_imm),
        .id_rd_in        (id_rd),
        .ex_valid_out    (ex_valid),
        .ex_ready_in     (ex_ready),
        .ex_result_out   (ex_result),
        .ex_store_out    (ex_store),
        .ex_rd_out       (ex_rd),
        .ex_funct3_out   (ex_funct3),
        .ex_is_mem_out   (ex_is_mem),
        .redirect_out    (redirect),
        .redirect_pc_out (redirect_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] cls, input logic [2:0] f3, input logic diff,
                                input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] exp_res,
                                input logic [4:0] exp_rd, input logic exp_mem, input logic exp_redir,
                                input logic [31:0] exp_rpc);
        vec_t v;
        v.cls = cls; v.f3 = f3; v.diff = diff; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.rd = rd; v.exp_res = exp_res; v.exp_rd = exp_rd; v.exp_mem = exp_mem;
        v.exp_redir = exp_redir; v.exp_rpc = exp_rpc;
        return v;
    endfunction

    task automatic drive(input logic [2:0] cls, input logic [2:0] f3, input logic diff,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd);
        id_valid = 1'b1; id_class = cls; id_funct3 = f3; id_diff = diff;
        id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_imm = imm; id_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        id_valid = 1'b0; id_class = '0; id_funct3 = '0; id_diff = 1'b0;
        id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_imm = '0; id_rd = '0;

        vecs[0]  = mk(EX_OP,    F3_ADD_SUB, 1'b0, 32'h0,        32'd5,        32'd7,        32'h0,        5'd3, 32'd12,       5'd3, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(EX_OP,    F3_ADD_SUB, 1'b1, 32'h0,        32'd10,       32'd3,        32'h0,        5'd4, 32'd7,        5'd4, 1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(EX_OP,    F3_SRL_SRA, 1'b1, 32'h0,        32'h80000000, 32'd4,        32'h0,        5'd5, 32'hF8000000, 5'd5, 1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(EX_OP,    F3_SLTU,    1'b0, 32'h0,        32'd1,        32'hFFFFFFFF, 32'h0,        5'd6, 32'd1,        5'd6, 1'b0, 1'b0, 32'h0);
        vecs[4]  = mk(EX_OPI,   F3_ADD_SUB, 1'b0, 32'h0,        32'hFFFFFFFF, 32'd99,       32'd1,        5'd7, 32'd0,        5'd7, 1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(EX_OPI,   F3_XOR,     1'b0, 32'h0,        32'h0000F0F0, 32'd0,        32'h000000FF, 5'd8, 32'h0000F00F, 5'd8, 1'b0, 1'b0, 32'h0);
        vecs[6]  = mk(EX_LUI,   3'd0,       1'b0, 32'h0,        32'h0,        32'h0,        32'h12345000, 5'd9, 32'h12345000, 5'd9, 1'b0, 1'b0, 32'h0);
        vecs[7]  = mk(EX_AUIPC, 3'd0,       1'b0, 32'h1000,     32'h0,        32'h0,        32'h2000,     5'd10, 32'h3000,    5'd10, 1'b0, 1'b0, 32'h0);
        vecs[8]  = mk(EX_CMP,   F3_BLT,     1'b0, 32'h100,      32'hFFFFFFFF, 32'd1,        32'hFFFFFFF8, 5'd5, 32'd1,        5'd0, 1'b0, 1'b1, 32'h000000F8);
        vecs[9]  = mk(EX_CMP,   F3_BEQ,     1'b0, 32'h100,      32'd1,        32'd2,        32'h10,       5'd5, 32'd0,        5'd0, 1'b0, 1'b0, 32'h0);
        vecs[10] = mk(EX_JAL,   3'd0,       1'b0, 32'h400,      32'h0,        32'h0,        32'h10,       5'd1, 32'h404,      5'd1, 1'b0, 1'b1, 32'h410);
        vecs[11] = mk(EX_JALR,  3'd0,       1'b0, 32'h200,      32'h1003,     32'h0,        32'h0,        5'd1, 32'h204,      5'd1, 1'b0, 1'b1, 32'h1002);
        vecs[12] = mk(EX_MEM,   3'd2,       1'b0, 32'h0,        32'h1000,     32'hCAFE,     32'hFFFFFFFC, 5'd7, 32'hFFC,      5'd7, 1'b1, 1'b0, 32'h0);
        vecs[13] = mk(EX_JAL,   3'd0,       1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h6,        5'd2, 32'h0,        5'd2, 1'b0, 1'b1, 32'h2);
        vecs[14] = mk(EX_OP,    F3_SLL,     1'b1, 32'h0,        32'd3,        32'd1,        32'h0,        5'd9, 32'd0,        5'd9, 1'b0, 1'b0, 32'h0);
        vecs[15] = mk(EX_CMP,   3'd2,       1'b0, 32'h80,       32'd1,        32'd1,        32'h8,        5'd3, 32'd0,        5'd0, 1'b0, 1'b0, 32'h0);

        // Reset state
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_result",   ex_result, 32'd0);
        chk("rst_rpc",      redirect_pc, 32'd0);
        #6 rst_n = 1'b1;
        tick();
        chk("idle_id_ready", {31'd0, id_ready}, 32'd1);

        // Vector table, one instruction at a time with the stage drained between
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cls, vecs[i].f3, vecs[i].diff, vecs[i].pc, vecs[i].rs1,
                  vecs[i].rs2, vecs[i].imm, vecs[i].rd);
            tick();
            id_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i),    {31'd0, ex_valid}, 32'd1);
            chk($sformatf("v%0d_result", i),   ex_result, vecs[i].exp_res);
            chk($sformatf("v%0d_rd", i),       {27'd0, ex_rd}, {27'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_store", i),    ex_store, vecs[i].rs2);
            chk($sformatf("v%0d_funct3", i),   {29'd0, ex_funct3}, {29'd0, vecs[i].f3});
            chk($sformatf("v%0d_is_mem", i),   {31'd0, ex_is_mem}, {31'd0, vecs[i].exp_mem});
            chk($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].exp_redir});
            chk($sformatf("v%0d_id_ready", i), {31'd0, id_ready}, {31'd0, !vecs[i].exp_redir});
            if (vecs[i].exp_redir)
                chk($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].exp_rpc);
            tick();
            chk($sformatf("v%0d_redir_clear", i), {31'd0, redirect}, 32'd0);
            chk($sformatf("v%0d_drained", i),     {31'd0, ex_valid}, 32'd0);
        end

        // Back-pressure: SUB(10,3) held three cycles, queued ADD(1,2) taken on release
        drive(EX_OP, F3_ADD_SUB, 1'b1, 32'h0, 32'd10, 32'd3, 32'h0, 5'd4);
        tick();
        drive(EX_OP, F3_ADD_SUB, 1'b0, 32'h0, 32'd1, 32'd2, 32'h0, 5'd6);
        ex_ready = 1'b0;
        #1;
        chk("bp_id_ready_0", {31'd0, id_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", c),  {31'd0, ex_valid}, 32'd1);
            chk($sformatf("bp_hold_result%0d", c), ex_result, 32'd7);
            chk($sformatf("bp_hold_rd%0d", c),     {27'd0, ex_rd}, 32'd4);
            chk($sformatf("bp_hold_ready%0d", c),  {31'd0, id_ready}, 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, id_ready}, 32'd1);
        tick();
        id_valid = 1'b0;
        chk("bp_next_valid",  {31'd0, ex_valid}, 32'd1);
        chk("bp_next_result", ex_result, 32'd3);
        chk("bp_next_rd",     {27'd0, ex_rd}, 32'd6);
        tick();

        // Flush while full and stalled, with a taken jump waiting on the input
        drive(EX_OP, F3_ADD_SUB, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3);
        tick();
        ex_ready = 1'b0;
        flush = 1'b1;
        drive(EX_JAL, 3'd0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h10, 5'd1);
        #1;
        chk("fl_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("fl_valid",    {31'd0, ex_valid}, 32'd0);
        chk("fl_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("fl_not_taken", {31'd0, ex_valid}, 32'd0);
        chk("fl_no_redir",  {31'd0, redirect}, 32'd0);
        ex_ready = 1'b1;

        // Asynchronous reset in the middle of a redirect
        drive(EX_JAL, 3'd0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h10, 5'd1);
        tick();
        id_valid = 1'b0;
        chk("ar_redirect_set", {31'd0, redirect}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid",    {31'd0, ex_valid}, 32'd0);
        chk("ar_redirect", {31'd0, redirect}, 32'd0);
        chk("ar_rpc",      redirect_pc, 32'd0);
        chk("ar_result",   ex_result, 32'd0);
        chk("ar_rd",       {27'd0, ex_rd}, 32'd0);
        #2 rst_n = 1'b1;
        drive(EX_OP, F3_ADD_SUB, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3);
        tick();
        id_valid = 1'b0;
        chk("ar_after_valid",    {31'd0, ex_valid}, 32'd1);
        chk("ar_after_result",   ex_result, 32'd12);
        chk("ar_after_redirect", {31'd0, redirect}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute pipeline stage. Sits between decode (upstream) and memory/writeback (downstream), and drives the existing combinational ALU.
- Selects ALU operands, resolves branches and jumps, and computes link values and memory addresses.
- Registers one result per instruction behind a valid/ready handshake.
- Issues a one-cycle redirect pulse to fetch/decode on a taken branch or jump.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- flush_in  in  1  external kill of the stage contents (trap/exception).
- id_valid_in  in  1  decode presents an instruction.
- id_ready_out  out  1  stage accepts an instruction this cycle.
- id_class_in  in  3  op class (EX_CMP/EX_OP/EX_OPI/EX_LUI/EX_AUIPC/EX_JAL/EX_JALR/EX_MEM).
- id_funct3_in  in  3  funct3, passed to the ALU as ins_details.
- id_diff_in  in  1  funct7[5], passed to the ALU as ins_diff.
- id_pc_in  in  32  instruction PC.
- id_rs1_in  in  32  rs1 value.
- id_rs2_in  in  32  rs2 value.
- id_imm_in  in  32  sign-extended immediate.
- id_rd_in  in  5  destination register.
- ex_valid_out  out  1  result register holds a valid instruction.
- ex_ready_in  in  1  downstream accepts the result.
- ex_result_out  out  32  ALU result, link value, LUI/AUIPC value, or memory address.
- ex_store_out  out  32  rs2 value, used as store data.
- ex_rd_out  out  5  destination register; 0 when the instruction does not write.
- ex_funct3_out  out  3  funct3, used by memory for width/sign.
- ex_is_mem_out  out  1  result is a memory address.
- redirect_out  out  1  one-cycle taken-branch/jump pulse.
- redirect_pc_out  out  32  new fetch PC.

Behaviour:
- Reset (rst_in=0, asynchronous): all outputs 0; the stage is empty.
- Handshake: id_ready_out = (!ex_valid_out | ex_ready_in) & !redirect_out & !flush_in.
- Accept: occurs when id_valid_in & id_ready_out. Result is registered at the next edge, so latency is 1 cycle.
- Hold: if ex_valid_out & !ex_ready_in, all ex_* outputs hold stable.
- Drain: when ex_ready_in=1 and nothing is accepted, ex_valid_out falls to 0 at the next edge.
- Operand/result rules by class:
  - EX_CMP: ALU type ALU_CMP, r1=rs1, r2=rs2. Taken iff the ALU returns TrueWord. Target = pc+imm. ex_rd_out=0; result = ALU output.
  - EX_OP: ALU_ALUOP, r2=rs2.
  - EX_OPI: ALU_ALUOPI, r2=imm.
  - EX_LUI: result = imm.
  - EX_AUIPC: result = pc+imm.
  - EX_JAL: result = pc+4; always taken; target = pc+imm.
  - EX_JALR: result = pc+4; always taken; target = (rs1+imm) with bit0 cleared.
  - EX_MEM: result = rs1+imm; ex_is_mem_out=1.
- Arithmetic: all adds are mod 2^32 and wrap silently. Misaligned targets (bit1 set) are redirected unchanged; this block raises no exception.
- Redirect: asserted for exactly the cycle after a taken instruction is accepted, with redirect_pc_out valid that cycle. It then clears to 0 at the following edge, regardless of the downstream stall.
  - During the redirect cycle the stage refuses input, so the wrong-path instruction decode holds is never accepted. Decode flushes itself on redirect_out.
- States:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on ex_ready_in with no accept.
  - FULL → FULL on accept with ex_ready_in, or on stall.
  - REDIRECT is a flag overlaid on FULL for one cycle.
- flush_in (synchronous, highest priority):
  - Next edge: ex_valid_out=0 and redirect_out=0; a same-cycle input is dropped.
  - A simultaneous downstream handshake still completes; downstream owns that instruction.
- Reset mid-operation: immediate clear; a pending redirect is lost.
- Illegal class/funct3 combinations: result = 0 and rd still forwarded; no hang.

Decomposition:
- Shared package/defines holds:
  - the EX_* class codes;
  - the existing ALU_CMP/ALU_ALUOP/ALU_ALUOPI codes, funct3 codes, *_Diff values, and TrueWord/FalseWord/ZeroWord.
- Sub-module: the existing ALU, instantiated once. A separate branch-target adder is kept inside ex_stage; no other sub-module.

Test Plan:
- ADD: rs1=5, rs2=7, OP/ADD_SUB, diff=0 → next cycle ex_valid_out=1, result=12, rd forwarded, redirect_out=0.
- Taken BLT: rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=-8 →
  - redirect_out=1 for one cycle, redirect_pc_out=0xF8;
  - id_ready_out=0 that cycle;
  - ex_rd_out=0.
- JALR: pc=0x200, rs1=0x1003, imm=0 → result=0x204, redirect_pc_out=0x1002.
- Back-pressure: ex_ready_in=0 for 3 cycles after SUB(10,3) → result=7 held stable, id_ready_out=0. On release, the queued instruction is accepted the same cycle.
- Flush with id_valid_in=1 and ex_valid_out=1, ex_ready_in=0 → next cycle ex_valid_out=0, the input is not taken, redirect_out=0.
- Async reset pulsed mid-redirect → all outputs 0 immediately; the following accept behaves normally.
